// File: rtl/mod_mult_if.sv
// mod_mult_if: operand/result handshake bundle for mod_mult_pipe.
//   master: drives in_valid, in_mode, in_a, in_b, in_c, in_tag, out_ready
//   slave : drives in_ready, out_valid, out_res, out_tag
interface mod_mult_if #(
    parameter int W     = 12,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     in_c;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_mode, in_a, in_b, in_c, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag
    );
    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_c, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag
    );
endinterface

// File: rtl/mod_mult_pipe.sv
// mod_mult_pipe: pipelined (a*b) mod Q / (a*b + c) mod Q using Barrett reduction.
//   clk, rst : clock and synchronous active-high reset
//   m        : mod_mult_if.slave carrying in_* operands/tag and out_* result/tag
//              with valid/ready handshakes on both sides
// An op captured at edge n is presented on out_* after edge n+4. All registers
// advance together on en = !out_valid | out_ready, so a stalled output freezes
// the whole pipe and in_ready follows en combinationally.
module mod_mult_pipe #(
    parameter int W     = 12,
    parameter int Q     = 3329,
    parameter int TAG_W = 8
) (
    input logic      clk,
    input logic      rst,
    mod_mult_if.slave m
);
    localparam int K = 2 * W;
    localparam logic [K-1:0] M_C = K'((64'd1 << K) / 64'(Q));
    localparam logic [K-1:0] QK  = K'(Q);
    localparam logic [W+1:0] QR  = (W + 2)'(Q);
    localparam logic [W-1:0] QW  = W'(Q);

    logic [4:0]       v;
    logic             en;
    logic [W-1:0]     s1_a, s1_b, s1_c;
    logic [K-1:0]     s2_x, s3_x, s3_q;
    logic [W+1:0]     s4_r;
    logic [TAG_W-1:0] s1_t, s2_t, s3_t, s4_t, o_tag;
    logic [W-1:0]     o_res;
    logic [K-1:0]     x_d, q_d;
    logic [W+1:0]     r_d, c1, c2;

    assign en = !v[4] | m.out_ready;

    assign m.in_ready  = en;
    assign m.out_valid = v[4];
    assign m.out_res   = o_res;
    assign m.out_tag   = o_tag;

    // x = a*b + c never exceeds Q^2-1 for legal operands, so K bits suffice.
    // qhat under-estimates floor(x/Q) by at most 2, so r0 fits in W+2 bits
    // and the true remainder is recovered with at most two subtractions.
    // The qhat multiply and the qhat*Q multiply sit in separate stages so no
    // two wide multipliers are chained in one cycle.
    always_comb begin
        x_d = K'(s1_a) * K'(s1_b) + K'(s1_c);
        q_d = K'(((2 * K)'(s2_x) * (2 * K)'(M_C)) >> K);
        r_d = (W + 2)'(s3_x - K'(s3_q * QK));
        c1  = s4_r >= QR ? s4_r - QR : s4_r;
        c2  = c1 >= QR ? c1 - QR : c1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            o_res <= '0;
            o_tag <= '0;
        end else if (en) begin
            v     <= {v[3:0], m.in_valid};
            o_res <= W'(c2);
            o_tag <= s4_t;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_a <= m.in_a;
            s1_b <= m.in_b;
            s1_c <= m.in_mode ? m.in_c : '0;
            s1_t <= m.in_tag;
            s2_x <= x_d;
            s2_t <= s1_t;
            s3_x <= s2_x;
            s3_q <= q_d;
            s3_t <= s2_t;
            s4_r <= r_d;
            s4_t <= s3_t;
        end
    end

    a_legal_operands: assert property (@(posedge clk) disable iff (rst)
        (m.in_valid && en) |-> (m.in_a < QW && m.in_b < QW && (!m.in_mode || m.in_c < QW)));
endmodule

// File: tb/tb_mod_mult_pipe.sv
// tb_mod_mult_pipe: directed and random self-checking bench for mod_mult_pipe.
module tb_mod_mult_pipe;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;
    int tag_base = 0;
    logic [11:0] q_a[$], q_b[$], q_c[$];
    logic        q_m[$];
    int          q_e[$];

    always #5 clk = ~clk;

    mod_mult_if #(.W(12), .TAG_W(8)) bus ();

    mod_mult_pipe #(.W(12), .Q(3329), .TAG_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .m  (bus)
    );

    task automatic clear_ops();
        q_a.delete(); q_b.delete(); q_c.delete(); q_m.delete(); q_e.delete();
    endtask

    task automatic add_op(input int a, input int b, input int c, input bit md, input int e);
        q_a.push_back(12'(a)); q_b.push_back(12'(b)); q_c.push_back(12'(c));
        q_m.push_back(md); q_e.push_back(e);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            int a, b, c;
            bit md;
            a = $urandom_range(3328); b = $urandom_range(3328); c = $urandom_range(3328);
            md = 1'($urandom_range(1));
            add_op(a, b, c, md, (a * b + (md ? c : 0)) % 3329);
        end
    endtask

    // Entered and left at posedge+1. Drives the queued ops with tags
    // tag_base+i, scoreboards results in order and checks stall stability.
    task automatic run_ops(input string name, input int rdy_pct);
        int n, sent, got, cyc;
        bit stalled;
        logic [11:0] hold_res;
        logic [7:0] hold_tag, etag;
        n = q_a.size(); sent = 0; got = 0; cyc = 0; stalled = 0;
        hold_res = '0; hold_tag = '0;
        while (got < n && cyc < n * 10 + 50) begin
            bus.in_valid = sent < n;
            if (sent < n) begin
                bus.in_a = q_a[sent]; bus.in_b = q_b[sent]; bus.in_c = q_c[sent];
                bus.in_mode = q_m[sent]; bus.in_tag = 8'(tag_base + sent);
            end
            bus.out_ready = $urandom_range(99) < rdy_pct;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_res !== hold_res || bus.out_tag !== hold_tag) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b res=%0d tag=%h, expected v=1 res=%0d tag=%h",
                             name, bus.out_valid, bus.out_res, bus.out_tag, hold_res, hold_tag);
                end
            end
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++;
                $display("FAIL %s in_ready: got %b expected %b", name, bus.in_ready,
                         !bus.out_valid || bus.out_ready);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                etag = 8'(tag_base + got);
                checks++;
                if (bus.out_res !== 12'(q_e[got]) || bus.out_tag !== etag) begin
                    errors++;
                    $display("FAIL %s result[%0d]: got res=%0d tag=%h expected res=%0d tag=%h",
                             name, got, bus.out_res, bus.out_tag, q_e[got], etag);
                end
                got++;
            end
            stalled = bus.out_valid === 1'b1 && !bus.out_ready;
            hold_res = bus.out_res; hold_tag = bus.out_tag;
            if (bus.in_valid && bus.in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s count: got %0d results expected %0d", name, got, n);
        end
        if (rdy_pct == 100) begin
            checks++;
            if (cyc != n + 5) begin
                errors++;
                $display("FAIL %s throughput: got %0d cycles expected %0d", name, cyc, n + 5);
            end
        end
        tag_base += n;
    endtask

    task automatic test_reset();
        rst = 1; bus.in_valid = 0; bus.in_mode = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_c = 0; bus.in_tag = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_res !== 12'd0 || bus.out_tag !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b res=%0d tag=%h expected v=0 res=0 tag=00",
                     bus.out_valid, bus.out_res, bus.out_tag);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        bus.in_valid = 1; bus.in_mode = 0; bus.in_a = 12'd1234; bus.in_b = 12'd2345;
        bus.in_c = 12'd77; bus.in_tag = 8'h11; bus.out_ready = 1;
        @(posedge clk); #1;
        bus.in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'(k == 4)) begin
                errors++;
                $display("FAIL latency edge+%0d: got out_valid=%b expected %b", k, bus.out_valid, k == 4);
            end
        end
        checks++;
        if (bus.out_res !== 12'd829 || bus.out_tag !== 8'h11) begin
            errors++;
            $display("FAIL latency_result: got res=%0d tag=%h expected res=829 tag=11",
                     bus.out_res, bus.out_tag);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_no_dup: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_boundary();
        clear_ops();
        add_op(3328, 3328, 0, 0, 1);
        add_op(0, 3328, 0, 0, 0);
        add_op(1, 3328, 0, 0, 3328);
        add_op(2, 3, 100, 0, 6);
        run_ops("boundary", 100);
    endtask

    task automatic test_mac();
        clear_ops();
        add_op(3328, 3328, 3328, 1, 0);
        add_op(2, 3, 3328, 1, 5);
        add_op(0, 0, 3328, 1, 3328);
        run_ops("mac", 100);
    endtask

    task automatic test_back_to_back();
        clear_ops();
        add_random(256);
        run_ops("back_to_back", 100);
    endtask

    task automatic test_backpressure();
        clear_ops();
        add_random(500);
        run_ops("backpressure", 50);
    endtask

    task automatic test_reset_flight();
        int seen;
        bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_mode = 0; bus.in_a = 12'(i + 1); bus.in_b = 12'(i + 2);
            bus.in_tag = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flight_reset_valid: got %b expected 0", bus.out_valid);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        @(posedge clk); #1;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flight_flushed: got %0d valid cycles expected 0", seen);
        end
        clear_ops();
        add_op(5, 7, 0, 0, 35);
        run_ops("after_reset", 100);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundary();
        test_mac();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
